muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have clrn  input  1  reset, synchronous and active-low, sampled on rising clk.
REQ-003 SHALL have start  input  1  request pulse; accepted only when busy is low.
REQ-004 SHALL have funct3  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-005 SHALL have op_a  input  32  rs1 operand from the register file read port A.
REQ-006 SHALL have op_b  input  32  rs2 operand from the register file read port B.
REQ-007 SHALL have rd  input  5  destination register index.
REQ-008 SHALL have busy  output  1  high whenever the state is not IDLE.
REQ-009 SHALL have done  output  1  one-cycle completion pulse.
REQ-010 SHALL have result  output  32  value for the register file write port.
REQ-011 SHALL have write_addr  output  5  destination index for the register file.
REQ-012 SHALL have we  output  1  register file write enable.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, DONE:
- IDLE->CALC on accepted start.
- CALC->DONE when the iteration counter reaches 0.
- DONE->IDLE unconditionally after one cycle.
REQ-014 SHALL, on accept, latch funct3, rd, op_a and op_b, and load the iteration counter with 31.
REQ-015 SHALL ignore start while busy is high, including in the DONE cycle.
REQ-016 SHALL perform one radix-2 iteration per CALC cycle: shift-add for multiply, restoring shift-subtract for divide.
REQ-017 SHALL keep a 64-bit product and a 32-bit quotient/remainder internally.
REQ-018 SHALL form the result as follows:
- MUL: low 32 bits of the product.
- MULH, MULHSU, MULHU: high 32 bits, with signed×signed, signed×unsigned and unsigned×unsigned operands respectively.
- DIV, REM: truncate toward zero; the remainder takes the sign of the dividend.
REQ-019 SHALL implement signed ops by magnitude arithmetic on absolute values, with sign correction applied on entry to DONE.
REQ-020 SHALL handle divide-by-zero (op_b==0) without iterating, going IDLE->DONE directly:
- DIV, DIVU: result 0xFFFFFFFF.
- REM, REMU: result = op_a.
REQ-021 SHALL handle signed overflow (DIV/REM with op_a 0x80000000, op_b 0xFFFFFFFF) without iterating, going IDLE->DONE directly:
- DIV: result 0x80000000.
- REM: result 0.
REQ-022 SHALL have latency, measured from the accepting edge: done high in the 33rd cycle for iterative ops; done high in the 1st cycle for the special cases.
REQ-023 SHALL assert done only in the DONE state.
REQ-024 SHALL drive we = done AND (write_addr != 0).
REQ-025 SHALL hold result and write_addr stable from DONE until the next accepted start.
REQ-026 SHALL allow the next start to be accepted in the cycle immediately following DONE, giving back-to-back throughput of 1 op per 34 cycles.
REQ-027 SHALL sample op_a, op_b and funct3 only at accept; later input changes have no effect on the result.

Reset
REQ-028 SHALL, when clrn is low at a rising clk:
- force state IDLE;
- set busy=0, done=0, we=0, result=0, write_addr=0;
- clear the counter and datapath registers.
REQ-029 SHALL, when reset is applied mid-CALC, discard the in-flight op, with no done or we pulse ever issued for it.
REQ-030 SHALL give reset priority over start in the same cycle.

Verification
REQ-031 SHALL pass: MUL, op_a=7, op_b=0xFFFFFFFD, rd=5 -> done in cycle 33, result=0xFFFFFFEB, write_addr=5, we=1 for exactly one cycle.
REQ-032 SHALL pass: MULH, op_a=op_b=0x80000000 -> result 0x40000000; the same operands with MULHU -> result 0x40000000; MULHSU with op_a=0xFFFFFFFF, op_b=2 -> result 0xFFFFFFFF.
REQ-033 SHALL pass: DIVU 100/7 -> result 14; REMU 100/7 -> result 2; DIV 0xFFFFFF9C/7 -> result 0xFFFFFFF2; REM 0xFFFFFF9C/7 -> result 0xFFFFFFFE.
REQ-034 SHALL pass: DIV with op_b=0 -> result 0xFFFFFFFF with done in cycle 1; REM 0x80000000/0xFFFFFFFF -> result 0 with done in cycle 1.
REQ-035 SHALL pass: start, then clrn low at cycle 10 for 1 cycle -> busy=0, no done or we pulse; a new start after reset completes normally.
REQ-036 SHALL pass: rd=0 with MUL 3*4 -> done=1, result=12, we=0; start held high throughout -> a second op is accepted only after DONE.

Source files
------------

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//
// Iterative RV32M multiply/divide unit. Each op takes one radix-2 step per
// clock. Multiplies use shift-add and divides use restoring shift-subtract.
// Both work on operand magnitudes, and the sign is fixed when the FSM enters
// DONE. Divide-by-zero and signed overflow skip the iterations and go
// straight to DONE.
//
// Ports
//   clk         rising-edge clock
//   clrn        synchronous active-low reset
//   start       request pulse, accepted only while busy is low
//   funct3      op select (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   op_a, op_b  rs1 / rs2 operands, sampled at accept only
//   rd          destination register index, sampled at accept
//   busy        high whenever the FSM is not IDLE
//   done        one-cycle completion pulse (DONE state)
//   result      result value, held from DONE until the next accept
//   write_addr  destination index, held from accept until the next accept
//   we          register-file write enable = done & (write_addr != 0)
// -----------------------------------------------------------------------------
module muldiv_unit (
  input  logic        clk,
  input  logic        clrn,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [4:0]  rd,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  write_addr,
  output logic        we
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_REM    = 3'b110;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  // The low half holds the multiplier (multiply) or the dividend/quotient
  // bits (divide). The high half is the partial product or partial remainder.
  logic [63:0] acc_q, acc_d;
  // Multiplicand magnitude (multiply) or divisor magnitude (divide).
  logic [31:0] mcand_q, mcand_d;
  logic [2:0]  f3_q, f3_d;
  logic        neg_q, neg_d;
  logic [31:0] result_q, result_d;
  logic [4:0]  waddr_q, waddr_d;

  // ---------------------------------------------------------------------------
  // Operand decode at accept
  // ---------------------------------------------------------------------------
  logic        a_signed, b_signed, a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic        div_zero, div_ovf, start_neg;

  always_comb begin
    a_signed  = (funct3 == F_MULH) || (funct3 == F_MULHSU) ||
                (funct3 == F_DIV)  || (funct3 == F_REM);
    b_signed  = (funct3 == F_MULH) || (funct3 == F_DIV) || (funct3 == F_REM);
    a_neg     = a_signed & op_a[31];
    b_neg     = b_signed & op_b[31];
    a_mag     = a_neg ? (32'd0 - op_a) : op_a;
    b_mag     = b_neg ? (32'd0 - op_b) : op_b;
    // A remainder takes the dividend's sign. Every other signed result takes
    // the XOR of the two operand signs.
    start_neg = (funct3 == F_REM) ? a_neg : (a_neg ^ b_neg);
    div_zero  = funct3[2] && (op_b == 32'd0);
    div_ovf   = ((funct3 == F_DIV) || (funct3 == F_REM)) &&
                (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);
  end

  // ---------------------------------------------------------------------------
  // One radix-2 step
  // ---------------------------------------------------------------------------
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_trial;
  logic [32:0] div_diff;
  logic        div_ge;
  logic [31:0] div_rem;
  logic [63:0] div_next;
  logic [63:0] acc_step;

  always_comb begin
    // Shift-add. The 33-bit sum keeps the carry, and that carry shifts into
    // bit 63.
    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mcand_q} : 33'd0);
    mul_next = {mul_sum, acc_q[31:1]};

    // Restoring divide. The partial remainder is always below the divisor, so
    // the shifted trial value fits in 33 bits.
    div_trial = {acc_q[63:32], acc_q[31]};
    div_diff  = div_trial - {1'b0, mcand_q};
    div_ge    = (div_trial >= {1'b0, mcand_q});
    div_rem   = div_ge ? div_diff[31:0] : div_trial[31:0];
    div_next  = {div_rem, acc_q[30:0], div_ge};

    acc_step  = f3_q[2] ? div_next : mul_next;
  end

  // ---------------------------------------------------------------------------
  // Sign correction of the final step, applied on entry to DONE
  // ---------------------------------------------------------------------------
  logic [63:0] prod_fix;
  logic [31:0] div_sel;
  logic [31:0] div_fix;
  logic [31:0] final_res;

  always_comb begin
    prod_fix = neg_q ? (64'd0 - acc_step) : acc_step;
    // f3_q[1] set means REM/REMU (the remainder is in the high half).
    div_sel  = f3_q[1] ? acc_step[63:32] : acc_step[31:0];
    div_fix  = neg_q ? (32'd0 - div_sel) : div_sel;
    if (f3_q[2]) begin
      final_res = div_fix;
    end else if (f3_q == F_MUL) begin
      final_res = prod_fix[31:0];
    end else begin
      final_res = prod_fix[63:32];
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state and datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    f3_d     = f3_q;
    neg_d    = neg_q;
    result_d = result_q;
    waddr_d  = waddr_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          f3_d    = funct3;
          waddr_d = rd;
          neg_d   = start_neg;
          cnt_d   = 5'd31;
          if (funct3[2]) begin
            acc_d   = {32'd0, a_mag};
            mcand_d = b_mag;
          end else begin
            acc_d   = {32'd0, b_mag};
            mcand_d = a_mag;
          end
          if (div_zero) begin
            // funct3[1] set means REM/REMU.
            result_d = funct3[1] ? op_a : 32'hFFFF_FFFF;
            state_d  = S_DONE;
          end else if (div_ovf) begin
            result_d = funct3[1] ? 32'd0 : 32'h8000_0000;
            state_d  = S_DONE;
          end else begin
            state_d  = S_CALC;
          end
        end
      end

      S_CALC: begin
        acc_d = acc_step;
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0) begin
          result_d = final_res;
          state_d  = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      acc_q    <= 64'd0;
      mcand_q  <= 32'd0;
      f3_q     <= 3'd0;
      neg_q    <= 1'b0;
      result_q <= 32'd0;
      waddr_q  <= 5'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      f3_q     <= f3_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      waddr_q  <= waddr_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign result     = result_q;
  assign write_addr = waddr_q;
  assign we         = done && (waddr_q != 5'd0);

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        clrn;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  rd;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  write_addr;
  logic        we;

  int checks = 0;
  int errors = 0;

  muldiv_unit dut (
    .clk        (clk),
    .clrn       (clrn),
    .start      (start),
    .funct3     (funct3),
    .op_a       (op_a),
    .op_b       (op_b),
    .rd         (rd),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .write_addr (write_addr),
    .we         (we)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Call at a sample point (#1 after posedge) with the unit idle.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] r,
                        input logic [31:0] exp_res, input int exp_lat);
    int cyc;
    funct3 = f; op_a = a; op_b = b; rd = r; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Scramble the inputs after accept. The result must not depend on them.
    op_a = ~a; op_b = b ^ 32'h5A5A_5A5A; funct3 = ~f; rd = ~r;
    check({tag, " busy"}, {31'd0, busy}, 32'd1);
    cyc = 1;
    while (done !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, " latency"}, cyc, exp_lat);
    check({tag, " result"}, result, exp_res);
    check({tag, " waddr"}, {27'd0, write_addr}, {27'd0, r});
    check({tag, " we"}, {31'd0, we}, {31'd0, (r != 5'd0)});
    @(posedge clk); #1;
    check({tag, " done_1cyc"}, {31'd0, done}, 32'd0);
    check({tag, " idle"}, {31'd0, busy}, 32'd0);
    check({tag, " hold"}, result, exp_res);
    $display("op %-10s f3=%b a=%h b=%h rd=%0d -> result=%h lat=%0d", tag, f, a, b, r, result, cyc);
  endtask

  initial begin
    int cyc;
    int pulses;

    // Reset, with start high at the same time
    clrn = 1'b0; start = 1'b1; funct3 = 3'b000; op_a = 32'd5; op_b = 32'd6; rd = 5'd3;
    repeat (3) @(posedge clk);
    #1;
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst we", {31'd0, we}, 32'd0);
    check("rst result", result, 32'd0);
    check("rst waddr", {27'd0, write_addr}, 32'd0);
    start = 1'b0; clrn = 1'b1;
    @(posedge clk); #1;
    $display("reset released");

    // Directed ops
    run_op("MUL",     3'b000, 32'd7,         32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 33);
    run_op("MULH",    3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000, 33);
    run_op("MULHU",   3'b011, 32'h8000_0000, 32'h8000_0000, 5'd7,  32'h4000_0000, 33);
    run_op("MULHSU",  3'b010, 32'hFFFF_FFFF, 32'd2,         5'd8,  32'hFFFF_FFFF, 33);
    run_op("MULHU2",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9,  32'hFFFF_FFFE, 33);
    run_op("DIVU",    3'b101, 32'd100,       32'd7,         5'd10, 32'd14,        33);
    run_op("REMU",    3'b111, 32'd100,       32'd7,         5'd11, 32'd2,         33);
    run_op("DIV",     3'b100, 32'hFFFF_FF9C, 32'd7,         5'd12, 32'hFFFF_FFF2, 33);
    run_op("REM",     3'b110, 32'hFFFF_FF9C, 32'd7,         5'd13, 32'hFFFF_FFFE, 33);
    run_op("DIVU_MAX",3'b101, 32'hFFFF_FFFF, 32'd1,         5'd14, 32'hFFFF_FFFF, 33);
    run_op("REMU_BIG",3'b111, 32'hFFFF_FFFF, 32'h8000_0000, 5'd15, 32'h7FFF_FFFF, 33);
    run_op("DIV_Z",   3'b100, 32'd1234,      32'd0,         5'd16, 32'hFFFF_FFFF, 1);
    run_op("REMU_Z",  3'b111, 32'd1234,      32'd0,         5'd17, 32'd1234,      1);
    run_op("REM_OVF", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'd0,         1);
    run_op("DIV_OVF", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd19, 32'h8000_0000, 1);

    // Reset in the middle of CALC
    funct3 = 3'b000; op_a = 32'd9; op_b = 32'd9; rd = 5'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    clrn = 1'b0;
    @(posedge clk); #1;
    check("midrst busy", {31'd0, busy}, 32'd0);
    check("midrst done", {31'd0, done}, 32'd0);
    check("midrst we", {31'd0, we}, 32'd0);
    check("midrst result", result, 32'd0);
    clrn = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1 || we === 1'b1) pulses++;
    end
    check("midrst no pulse", pulses, 0);
    $display("mid-CALC reset: pulses after reset=%0d", pulses);
    run_op("MUL_AFTER", 3'b000, 32'd6, 32'd7, 5'd1, 32'd42, 33);

    // rd=0 with start held high: the DONE cycle must not accept it
    funct3 = 3'b000; op_a = 32'd3; op_b = 32'd4; rd = 5'd0; start = 1'b1;
    @(posedge clk); #1;
    cyc = 1;
    while (done !== 1'b1 && cyc < 40) begin @(posedge clk); #1; cyc++; end
    check("held lat", cyc, 33);
    check("held result", result, 32'd12);
    check("held we", {31'd0, we}, 32'd0);
    check("held done", {31'd0, done}, 32'd1);
    @(posedge clk); #1;
    check("held idle after done", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    check("held second accept", {31'd0, busy}, 32'd1);
    start = 1'b0; op_a = 32'd100;
    cyc = 1;
    while (done !== 1'b1 && cyc < 40) begin @(posedge clk); #1; cyc++; end
    check("held2 lat", cyc, 33);
    check("held2 result", result, 32'd12);
    $display("held-start sequence: second result=%h lat=%0d", result, cyc);
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
